// File: rtl/aes_dec_block_loader_pkg.sv
// Shared definitions for the AES decryption block loader: FSM state encoding,
// block geometry and the set of legal key lengths.
package aes_dec_block_loader_pkg;

  // Loader FSM states (2-bit encoding, also exported on the debug port)
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEY  = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } loaderState_t;

  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int BLOCK_W         = WORD_W * WORDS_PER_BLOCK;

  // AES-128/192/256 key lengths in 32-bit words
  localparam int NK_LEGAL_0 = 4;
  localparam int NK_LEGAL_1 = 6;
  localparam int NK_LEGAL_2 = 8;

  function automatic bit nkLegal(input int nk);
    return (nk == NK_LEGAL_0) || (nk == NK_LEGAL_1) || (nk == NK_LEGAL_2);
  endfunction

endpackage

// File: rtl/aes_dec_block_loader.sv
// Upstream feeder for the combinational AES decryption core. Collects key and
// ciphertext words (MSB word first) from a 32-bit valid/ready stream, holds a
// complete block plus the sticky key stable until the consumer acknowledges.
//
// Handshake semantics: a word moves on a rising edge when s_valid && s_ready.
// s_ready depends only on the FSM state (low in HOLD, low in reset), never on
// s_valid or s_key. On the block side blk_valid stays high, with data_out and
// key_out frozen, until the edge on which blk_ready is seen high.
module aes_dec_block_loader
  import aes_dec_block_loader_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [31:0]        s_data,
  input  logic               s_key,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic [127:0]       data_out,
  output logic [Nk*32-1:0]   key_out,
  output logic               key_ok,
  output logic               err,
  output loaderState_t       dbgState,
  output logic [2:0]         dbgWordCnt
);

  localparam int         KEY_W     = Nk * WORD_W;
  localparam int         KEY_SEL_W = $clog2(KEY_W);
  localparam logic [2:0] KEY_LAST  = 3'(Nk - 1);
  localparam logic [2:0] DATA_LAST = 3'(WORDS_PER_BLOCK - 1);

  // Reject key lengths the core cannot handle and inconsistent round counts
  if (!nkLegal(Nk) || (Nr != Nk + 6)) begin : gBadParam
    $error("aes_dec_block_loader: illegal Nk/Nr combination");
  end

  loaderState_t          state;
  logic [2:0]            wordCnt;
  logic [BLOCK_W-1:0]    dataReg;
  logic [KEY_W-1:0]      keyReg;
  logic                  keyOkReg;
  logic                  blkValidReg;
  logic                  errReg;

  logic                  xfer;
  logic [KEY_SEL_W-1:0]  keyLsb;
  logic [6:0]            dataLsb;

  // Ready is a pure function of state; forced low while reset is asserted
  assign s_ready = rst_n && (state != ST_HOLD);
  assign xfer    = s_valid && s_ready;

  // Word i lands at the i-th 32-bit slot counted from the MSB end
  assign keyLsb  = KEY_SEL_W'(WORD_W * (Nk - 1 - int'(wordCnt)));
  assign dataLsb = 7'(WORD_W * (int'(DATA_LAST) - int'(wordCnt)));

  // Loader FSM: word assembly, key bookkeeping, block hold and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wordCnt     <= 3'd0;
      dataReg     <= '0;
      keyReg      <= '0;
      keyOkReg    <= 1'b0;
      blkValidReg <= 1'b0;
      errReg      <= 1'b0;
    end else begin
      errReg <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (xfer) begin
            if (s_key) begin
              // A new key load invalidates the old key immediately
              keyReg[KEY_W-1 -: WORD_W] <= s_data;
              wordCnt  <= 3'd1;
              keyOkReg <= 1'b0;
              state    <= ST_KEY;
            end else if (keyOkReg) begin
              dataReg[BLOCK_W-1 -: WORD_W] <= s_data;
              wordCnt <= 3'd1;
              state   <= ST_DATA;
            end else begin
              // Ciphertext without a key is meaningless: drop it
              errReg <= 1'b1;
            end
          end
        end

        ST_KEY: begin
          if (xfer) begin
            if (s_key) begin
              keyReg[keyLsb +: WORD_W] <= s_data;
              if (wordCnt == KEY_LAST) begin
                keyOkReg <= 1'b1;
                wordCnt  <= 3'd0;
                state    <= ST_IDLE;
              end else begin
                wordCnt <= wordCnt + 3'd1;
              end
            end else begin
              // Data interrupting a key load aborts the key
              keyOkReg <= 1'b0;
              wordCnt  <= 3'd0;
              errReg   <= 1'b1;
              state    <= ST_IDLE;
            end
          end
        end

        ST_DATA: begin
          if (xfer) begin
            if (!s_key) begin
              dataReg[dataLsb +: WORD_W] <= s_data;
              if (wordCnt == DATA_LAST) begin
                wordCnt     <= 3'd0;
                blkValidReg <= 1'b1;
                state       <= ST_HOLD;
              end else begin
                wordCnt <= wordCnt + 3'd1;
              end
            end else begin
              // Key word mid-block: partial block is lost, key load restarts
              keyReg[KEY_W-1 -: WORD_W] <= s_data;
              keyOkReg <= 1'b0;
              wordCnt  <= 3'd1;
              errReg   <= 1'b1;
              state    <= ST_KEY;
            end
          end
        end

        ST_HOLD: begin
          if (blk_ready) begin
            blkValidReg <= 1'b0;
            state       <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign blk_valid  = blkValidReg;
  assign data_out   = dataReg;
  assign key_out    = keyReg;
  assign key_ok     = keyOkReg;
  assign err        = errReg;
  assign dbgState   = state;
  assign dbgWordCnt = wordCnt;

endmodule

// File: tb/tb_aes_dec_block_loader.sv
// Self-checking bench for aes_dec_block_loader: an Nk=4 and an Nk=8 instance
// run side by side against a word-list reference model of the loader.
module tb_aes_dec_block_loader;
  import aes_dec_block_loader_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- DUT signals (index 0: Nk=4, index 1: Nk=8) ----------------
  logic         sValid[2];
  logic         sKey[2];
  logic [31:0]  sData[2];
  logic         blkReady[2];
  logic         sReady[2];
  logic         blkValid[2];
  logic         keyOk[2];
  logic         err[2];
  logic [127:0] dataOut[2];
  logic [127:0] keyOut4;
  logic [255:0] keyOut8;
  loaderState_t dbgState[2];
  logic [2:0]   dbgWordCnt[2];

  aes_dec_block_loader #(.Nk(4), .Nr(10)) u4 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(sValid[0]), .s_ready(sReady[0]), .s_data(sData[0]), .s_key(sKey[0]),
    .blk_valid(blkValid[0]), .blk_ready(blkReady[0]),
    .data_out(dataOut[0]), .key_out(keyOut4), .key_ok(keyOk[0]), .err(err[0]),
    .dbgState(dbgState[0]), .dbgWordCnt(dbgWordCnt[0])
  );

  aes_dec_block_loader #(.Nk(8), .Nr(14)) u8 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(sValid[1]), .s_ready(sReady[1]), .s_data(sData[1]), .s_key(sKey[1]),
    .blk_valid(blkValid[1]), .blk_ready(blkReady[1]),
    .data_out(dataOut[1]), .key_out(keyOut8), .key_ok(keyOk[1]), .err(err[1]),
    .dbgState(dbgState[1]), .dbgWordCnt(dbgWordCnt[1])
  );

  // ---------------- checker ----------------
  int checks = 0;
  int errors = 0;

  task automatic checkVal(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // The loader is modelled as two word lists: the key words gathered so far
  // and the ciphertext words gathered so far, plus the committed register
  // images that the outputs are expected to show.
  logic [31:0] mKey[2][8];
  logic [31:0] mData[2][4];
  int          mKeyCnt[2];
  int          mDataCnt[2];
  bit          mKeyOk[2];
  bit          mHold[2];
  bit          mErr[2];
  bit          mTook[2];

  function automatic int nkOf(input int sel);
    return (sel == 0) ? 4 : 8;
  endfunction

  function automatic void modelReset();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 8; i++) mKey[s][i] = '0;
      for (int i = 0; i < 4; i++) mData[s][i] = '0;
      mKeyCnt[s] = 0; mDataCnt[s] = 0;
      mKeyOk[s] = 0; mHold[s] = 0; mErr[s] = 0; mTook[s] = 0;
    end
  endfunction

  function automatic void modelEdge(input int sel);
    int nk = nkOf(sel);
    mTook[sel] = 0;
    mErr[sel]  = 0;
    if (mHold[sel]) begin
      if (blkReady[sel]) mHold[sel] = 0;
      return;
    end
    if (!sValid[sel]) return;
    mTook[sel] = 1;
    if (sKey[sel]) begin
      if (mKeyCnt[sel] > 0) begin
        mKey[sel][mKeyCnt[sel]] = sData[sel];
        mKeyCnt[sel]++;
        if (mKeyCnt[sel] == nk) begin
          mKeyOk[sel]  = 1;
          mKeyCnt[sel] = 0;
        end
      end else begin
        if (mDataCnt[sel] > 0) begin
          mErr[sel]     = 1;
          mDataCnt[sel] = 0;
        end
        mKey[sel][0] = sData[sel];
        mKeyCnt[sel] = 1;
        mKeyOk[sel]  = 0;
      end
    end else begin
      if (mKeyCnt[sel] > 0) begin
        mErr[sel]    = 1;
        mKeyCnt[sel] = 0;
        mKeyOk[sel]  = 0;
      end else if (mDataCnt[sel] > 0 || mKeyOk[sel]) begin
        mData[sel][mDataCnt[sel]] = sData[sel];
        mDataCnt[sel]++;
        if (mDataCnt[sel] == 4) begin
          mHold[sel]    = 1;
          mDataCnt[sel] = 0;
        end
      end else begin
        mErr[sel] = 1;
      end
    end
  endfunction

  function automatic logic [255:0] expKey(input int sel);
    logic [255:0] v = '0;
    int nk = nkOf(sel);
    for (int i = 0; i < nk; i++) v[(nk - 1 - i) * 32 +: 32] = mKey[sel][i];
    return v;
  endfunction

  function automatic logic [127:0] expData(input int sel);
    logic [127:0] v = '0;
    for (int i = 0; i < 4; i++) v[(3 - i) * 32 +: 32] = mData[sel][i];
    return v;
  endfunction

  function automatic loaderState_t expState(input int sel);
    if (mHold[sel])        return ST_HOLD;
    if (mKeyCnt[sel] > 0)  return ST_KEY;
    if (mDataCnt[sel] > 0) return ST_DATA;
    return ST_IDLE;
  endfunction

  function automatic logic [2:0] expCnt(input int sel);
    if (mKeyCnt[sel] > 0) return 3'(mKeyCnt[sel]);
    return 3'(mDataCnt[sel]);
  endfunction

  task automatic checkAll(input int sel);
    logic [255:0] kObs;
    kObs = (sel == 0) ? {128'b0, keyOut4} : keyOut8;
    checkVal($sformatf("s_ready%0d", sel),   256'(sReady[sel]),   256'(!mHold[sel]));
    checkVal($sformatf("blk_valid%0d", sel), 256'(blkValid[sel]), 256'(mHold[sel]));
    checkVal($sformatf("data_out%0d", sel),  256'(dataOut[sel]),  256'(expData(sel)));
    checkVal($sformatf("key_out%0d", sel),   kObs,                expKey(sel));
    checkVal($sformatf("key_ok%0d", sel),    256'(keyOk[sel]),    256'(mKeyOk[sel]));
    checkVal($sformatf("err%0d", sel),       256'(err[sel]),      256'(mErr[sel]));
    checkVal($sformatf("state%0d", sel),     256'(dbgState[sel]), 256'(expState(sel)));
    checkVal($sformatf("word_cnt%0d", sel),  256'(dbgWordCnt[sel]), 256'(expCnt(sel)));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idleInputs();
    for (int s = 0; s < 2; s++) begin
      sValid[s] = 1'b0; sKey[s] = 1'b0; sData[s] = '0; blkReady[s] = 1'b0;
    end
  endtask

  // One clock: model follows the edge, then every output is compared
  task automatic tick();
    @(posedge clk);
    modelEdge(0);
    modelEdge(1);
    #1;
    checkAll(0);
    checkAll(1);
  endtask

  task automatic sendWord(input int sel, input bit isKey, input logic [31:0] d);
    sValid[sel] = 1'b1; sKey[sel] = isKey; sData[sel] = d;
    tick();
    sValid[sel] = 1'b0; sKey[sel] = 1'b0;
  endtask

  task automatic release1(input int sel);
    blkReady[sel] = 1'b1;
    tick();
    blkReady[sel] = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, "_s_ready0"}, 256'(sReady[0]), 256'(0));
    checkVal({tag, "_s_ready1"}, 256'(sReady[1]), 256'(0));
    checkVal({tag, "_blk_valid0"}, 256'(blkValid[0]), 256'(0));
    checkVal({tag, "_key_ok0"}, 256'(keyOk[0]), 256'(0));
    checkVal({tag, "_key_ok1"}, 256'(keyOk[1]), 256'(0));
    checkVal({tag, "_data_out0"}, 256'(dataOut[0]), 256'(0));
    checkVal({tag, "_key_out4"}, 256'(keyOut4), 256'(0));
    checkVal({tag, "_key_out8"}, keyOut8, 256'(0));
    checkVal({tag, "_state0"}, 256'(dbgState[0]), 256'(ST_IDLE));
    checkVal({tag, "_err0"}, 256'(err[0]), 256'(0));
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic asyncReset(input string tag);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 checkResetOutputs(tag);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus tables ----------------
  logic [31:0] c1Key[4]  = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
  logic [31:0] c1Data[4] = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
  logic [31:0] c3Data[4] = '{32'h8ea2b7ca, 32'h516745bf, 32'heafc4990, 32'h4b496089};
  logic [127:0] c1Cipher = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic [127:0] c1KeyVal = 128'h000102030405060708090a0b0c0d0e0f;

  task automatic loadC1Key();
    for (int i = 0; i < 4; i++) sendWord(0, 1'b1, c1Key[i]);
  endtask

  task automatic loadC1Block();
    for (int i = 0; i < 4; i++) begin
      sendWord(0, 1'b0, c1Data[i]);
      checkVal($sformatf("c1_blk_valid_w%0d", i), 256'(blkValid[0]), 256'(i == 3));
    end
    checkVal("c1_data_out", 256'(dataOut[0]), 256'(c1Cipher));
    checkVal("c1_key_out", 256'(keyOut4), 256'(c1KeyVal));
  endtask

  int          burstLeft[2];
  bit          burstKey[2];
  logic [127:0] heldData;

  initial begin
    modelReset();
    idleInputs();
    rst_n = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Data word before any key: dropped, one-cycle err
    sendWord(0, 1'b0, 32'hdeadbeef);
    checkVal("nokey_err", 256'(err[0]), 256'(1));
    checkVal("nokey_key_ok", 256'(keyOk[0]), 256'(0));
    checkVal("nokey_state", 256'(dbgState[0]), 256'(ST_IDLE));
    tick();
    checkVal("nokey_err_cleared", 256'(err[0]), 256'(0));

    // FIPS-197 C.1 key and ciphertext
    loadC1Key();
    checkVal("c1_key_ok", 256'(keyOk[0]), 256'(1));
    loadC1Block();

    // Back-pressure: ten cycles of blk_ready low with a word on offer
    heldData = dataOut[0];
    sValid[0] = 1'b1; sKey[0] = 1'b0; sData[0] = 32'h12345678;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkVal("bp_s_ready", 256'(sReady[0]), 256'(0));
      checkVal("bp_data_stable", 256'(dataOut[0]), 256'(heldData));
    end
    sValid[0] = 1'b0;
    release1(0);
    checkVal("bp_blk_valid_drop", 256'(blkValid[0]), 256'(0));
    checkVal("bp_s_ready_back", 256'(sReady[0]), 256'(1));

    // Sticky key: second block with no key words
    for (int i = 0; i < 4; i++) begin
      sendWord(0, 1'b0, $urandom);
      checkVal("sticky_key_ok", 256'(keyOk[0]), 256'(1));
    end
    checkVal("sticky_key_out", 256'(keyOut4), 256'(c1KeyVal));
    release1(0);

    // Key word after two data words: err, restart key load at count 1
    sendWord(0, 1'b0, 32'haaaa0000);
    sendWord(0, 1'b0, 32'haaaa0001);
    sendWord(0, 1'b1, c1Key[0]);
    checkVal("dk_err", 256'(err[0]), 256'(1));
    checkVal("dk_state", 256'(dbgState[0]), 256'(ST_KEY));
    checkVal("dk_word_cnt", 256'(dbgWordCnt[0]), 256'(1));
    checkVal("dk_key_ok", 256'(keyOk[0]), 256'(0));
    for (int i = 1; i < 4; i++) sendWord(0, 1'b1, c1Key[i]);
    checkVal("dk_key_ok_after", 256'(keyOk[0]), 256'(1));

    // FIPS-197 C.3, Nk=8 instance
    for (int i = 0; i < 8; i++) sendWord(1, 1'b1, {4{8'(4 * i)}} + 32'h00010203);
    checkVal("c3_key_out", keyOut8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    for (int i = 0; i < 4; i++) sendWord(1, 1'b0, c3Data[i]);
    checkVal("c3_blk_valid", 256'(blkValid[1]), 256'(1));
    checkVal("c3_data_out", 256'(dataOut[1]), 256'h8ea2b7ca516745bfeafc49904b496089);
    release1(1);

    // Asynchronous reset mid-DATA, then mid-HOLD, each followed by a reload
    sendWord(0, 1'b0, 32'h11111111);
    sendWord(0, 1'b0, 32'h22222222);
    asyncReset("rst_data");
    tick();
    loadC1Key();
    loadC1Block();
    asyncReset("rst_hold");
    tick();
    loadC1Key();
    loadC1Block();
    release1(0);

    // Randomized traffic on both instances: mostly well-formed bursts with
    // occasional wrong-type words, random valid gaps and random back-pressure
    burstLeft[0] = 0; burstLeft[1] = 0;
    burstKey[0] = 0;  burstKey[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < 2; s++) begin
        if (burstLeft[s] == 0) begin
          burstKey[s]  = ($urandom_range(0, 9) < 3) || !mKeyOk[s];
          burstLeft[s] = burstKey[s] ? nkOf(s) : 4;
        end
        sValid[s]   = ($urandom_range(0, 3) != 0);
        sKey[s]     = burstKey[s] ^ ($urandom_range(0, 19) == 0);
        sData[s]    = $urandom;
        blkReady[s] = ($urandom_range(0, 2) == 0);
      end
      tick();
      for (int s = 0; s < 2; s++) if (mTook[s]) burstLeft[s]--;
    end
    idleInputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
